decoder_scan_sequencer: RTL

Timed row-scan sequencer that drives the 4-bit index and enable inputs of the 4-to-16 decoder stage. It walks the set bits of a 16-bit row mask in ascending order. For each row it holds a blanking gap (enable low) and then a programmable dwell (enable high). It repeats frames continuously until stopped. Typical use is LED-matrix or keypad row scanning, where the downstream decoder turns the index into a one-hot row select.

---
 rtl/decoder_scan_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/decoder_scan_sequencer.sv
// Row-scan sequencer: walks the set bits of a 16-bit row mask in ascending order,
// holding a blanking gap then a programmable dwell per row, frame after frame.
module decoder_scan_sequencer #(
   parameter int BLANK   = 2,
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [15:0]        row_mask,
   output logic [3:0]         binary_out,
   output logic               enable_out,
   output logic               busy,
   output logic               row_strobe,
   output logic               frame_done
);

   localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BLANK = 2'd1, S_DRIVE = 2'd2} state_t;

   state_t             r_state, w_state_nx;
   logic [3:0]         r_idx, w_idx_nx;
   logic [15:0]        r_mask, w_mask_nx;
   logic [DWELL_W-1:0] r_dwell, w_dwell_nx;
   logic [DWELL_W-1:0] r_dcnt, w_dcnt_nx;
   logic [BW-1:0]      r_bcnt, w_bcnt_nx;
   logic               r_stop_pend, w_stop_nx;
   logic               w_go_row, w_fdone_nx;
   logic [4:0]         w_next;
   logic [3:0]         w_bin_nx;
   logic               w_en_nx, w_busy_nx, w_strobe_nx;

   function automatic logic [3:0] f_lowest(input logic [15:0] m);
      f_lowest = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (m[i]) f_lowest = 4'(i);
   endfunction

   // Bit 4 flags that a set bit above idx exists; bits 3:0 give its position.
   function automatic logic [4:0] f_next_above(input logic [15:0] m, input logic [3:0] idx);
      f_next_above = 5'd0;
      for (int i = 15; i >= 0; i--)
         if (m[i] && (i > int'(idx))) f_next_above = {1'b1, 4'(i)};
   endfunction

   function automatic logic [DWELL_W-1:0] f_dwell_eff(input logic [DWELL_W-1:0] d);
      f_dwell_eff = (d == '0) ? DWELL_W'(1) : d;
   endfunction

   assign w_next = f_next_above(r_mask, r_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_mask      <= '0;
         r_dwell     <= '0;
         r_dcnt      <= '0;
         r_bcnt      <= '0;
         r_stop_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_idx       <= w_idx_nx;
         r_mask      <= w_mask_nx;
         r_dwell     <= w_dwell_nx;
         r_dcnt      <= w_dcnt_nx;
         r_bcnt      <= w_bcnt_nx;
         r_stop_pend <= w_stop_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_mask_nx  = r_mask;
      w_dwell_nx = r_dwell;
      w_dcnt_nx  = r_dcnt;
      w_bcnt_nx  = r_bcnt;
      w_stop_nx  = r_stop_pend;
      w_go_row   = 1'b0;
      w_fdone_nx = 1'b0;
      if (r_state != S_IDLE && stop) w_stop_nx = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (start && !stop && row_mask != '0) begin
               w_mask_nx  = row_mask;
               w_dwell_nx = f_dwell_eff(dwell);
               w_idx_nx   = f_lowest(row_mask);
               w_go_row   = 1'b1;
            end
         end
         S_BLANK: begin
            if (r_bcnt == '0) begin
               w_state_nx = S_DRIVE;
               w_dcnt_nx  = r_dwell - DWELL_W'(1);
            end else begin
               w_bcnt_nx = r_bcnt - BW'(1);
            end
         end
         S_DRIVE: begin
            if (r_dcnt != '0) begin
               w_dcnt_nx = r_dcnt - DWELL_W'(1);
            end else if (w_next[4]) begin
               w_idx_nx = w_next[3:0];
               w_go_row = 1'b1;
            end else begin
               // Frame boundary: a stop seen this very cycle still ends the scan here.
               w_fdone_nx = 1'b1;
               if (r_stop_pend || stop || row_mask == '0) begin
                  w_state_nx = S_IDLE;
                  w_stop_nx  = 1'b0;
               end else begin
                  w_mask_nx  = row_mask;
                  w_dwell_nx = f_dwell_eff(dwell);
                  w_idx_nx   = f_lowest(row_mask);
                  w_go_row   = 1'b1;
               end
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
      if (w_go_row) begin
         if (BLANK == 0) begin
            w_state_nx = S_DRIVE;
            w_dcnt_nx  = w_dwell_nx - DWELL_W'(1);
         end else begin
            w_state_nx = S_BLANK;
            w_bcnt_nx  = BW'(BLANK - 1);
         end
      end
   end

   // Outputs are decoded from the next state so they emerge from flops.
   always_comb begin
      w_busy_nx   = (w_state_nx != S_IDLE);
      w_en_nx     = (w_state_nx == S_DRIVE);
      w_bin_nx    = (w_state_nx == S_IDLE) ? 4'd0 : w_idx_nx;
      w_strobe_nx = (w_state_nx == S_DRIVE) && (w_dcnt_nx == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         binary_out <= 4'd0;
         enable_out <= 1'b0;
         busy       <= 1'b0;
         row_strobe <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         binary_out <= w_bin_nx;
         enable_out <= w_en_nx;
         busy       <= w_busy_nx;
         row_strobe <= w_strobe_nx;
         frame_done <= w_fdone_nx;
      end
   end

endmodule
